// File: rtl/xor_accum_pkg.sv
// Shared types and helpers for the xor_accum frame-parity block.
package xor_accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    // Bits needed to hold a beat count in the range 0..len inclusive.
    function automatic int cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/xor_accum_beat_ctr.sv
// Clear/increment beat counter that saturates at frame_len_p, with a flag
// raised when the next increment would complete the frame.
module xor_accum_beat_ctr
    import xor_accum_pkg::*;
#(
    parameter int frame_len_p = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            clr_i,
    input  logic                            inc_i,
    output logic [cnt_w(frame_len_p)-1:0]   cnt_o,
    output logic                            tc_o
);

    localparam int CW = cnt_w(frame_len_p);
    localparam logic [CW-1:0] MAX_LP  = CW'(frame_len_p);
    localparam logic [CW-1:0] LAST_LP = CW'(frame_len_p - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_LP)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == LAST_LP);

endmodule

// File: rtl/xor_accum.sv
// Streaming XOR reduction: folds frame_len_p input words into one result word.
// Define XOR_ACCUM_LAST_EN to add last_i for early frame termination.
module xor_accum
    import xor_accum_pkg::*;
#(
    parameter int width_p     = 8,
    parameter int frame_len_p = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    input  logic [width_p-1:0]              data_i,
`ifdef XOR_ACCUM_LAST_EN
    input  logic                            last_i,
`endif
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [width_p-1:0]              data_o,
    output logic [cnt_w(frame_len_p)-1:0]   count_o
);

    state_e               state_q, state_d;
    logic [width_p-1:0]   acc_q, acc_d;
    logic                 cnt_clr;
    logic                 cnt_inc;
    logic                 cnt_tc;
    logic                 frame_end;

`ifdef XOR_ACCUM_LAST_EN
    assign frame_end = cnt_tc | last_i;
`else
    assign frame_end = cnt_tc;
`endif

    xor_accum_beat_ctr #(
        .frame_len_p (frame_len_p)
    ) u_beat_ctr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .cnt_o     (count_o),
        .tc_o      (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            ACCUM: begin
                ready_o = 1'b1;
                // acc only moves on accepted beats, so bubble data never leaks in
                if (valid_i) begin
                    acc_d   = acc_q ^ data_i;
                    cnt_inc = 1'b1;
                    if (frame_end) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    acc_d   = '0;
                    cnt_clr = 1'b1;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ACCUM;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    // Partial sums stay hidden until the frame is complete.
    assign data_o = (state_q == DONE) ? acc_q : '0;

endmodule

// File: doc/xor_accum.md
Name: xor_accum

Overview:
Parametrised, sequential successor to the two-input XOR gate. Folds a stream of width_p-bit words into a running XOR over a frame of frame_len_p beats and presents one result word per frame. Uses valid/ready handshakes on both sides. Serves as the reduction/parity stage between streaming datapath blocks.

Parameters:
width_p, 8, data word width in bits (>=1)
frame_len_p, 4, beats per frame (>=1)

Ports:
clk_i  input  1  clock, rising edge
reset_n_i  input  1  asynchronous active-low reset
valid_i  input  1  input word valid
ready_o  output  1  block can accept input this cycle
data_i  input  width_p  input word
valid_o  output  1  frame result valid
ready_i  input  1  downstream accepts result
data_o  output  width_p  XOR of all words in the frame
count_o  output  $clog2(frame_len_p+1)  beats accepted in the current frame

Behaviour:
- Reset is asynchronous and active-low on reset_n_i; clock is clk_i. Reset forces:
  - state=ACCUM, acc=0, count=0
  - ready_o=1, valid_o=0, data_o=0, count_o=0
- Reset mid-frame or while a result is pending discards all partial and pending data.
- Input beat accepted when valid_i & ready_o. Output beat consumed when valid_o & ready_i.
- States (enum in package):
  - ACCUM:
    - ready_o=1, valid_o=0.
    - On accept: acc <= acc ^ data_i; count <= count+1.
    - If that beat is number frame_len_p: next state DONE, and acc takes the final XOR value.
  - DONE:
    - ready_o=0, valid_o=1, data_o=acc, count_o=frame_len_p.
    - Result is held stable until ready_i=1.
    - On consume: acc<=0, count<=0, next state ACCUM.
    - No input is accepted in the consume cycle.
- Latency: valid_o rises in the cycle after the last beat is accepted. Back-to-back frames therefore cost frame_len_p+1 cycles each with ready_i held high.
- data_o is registered (acc) and must not glitch or change while valid_o=1.
- data_o is 0 while in ACCUM.
- Arithmetic is pure bitwise XOR with no carries. Count saturates logically at frame_len_p and never wraps.
- frame_len_p=1: every accepted word goes straight to DONE with data_o=data_i.
- valid_i=0 cycles (bubbles) leave acc and count unchanged.
- data_i is don't-care when valid_i=0. X on data_i with valid_i=0 must not propagate into acc.

Optional Feature:
Macro XOR_ACCUM_LAST_EN.
- Defined:
  - Adds input port last_i (1 bit, qualified by valid_i).
  - An accepted beat with last_i=1 ends the frame early: DONE with count_o equal to the beats actually accepted, which ranges 1..frame_len_p.
  - last_i on beat frame_len_p is redundant and harmless.
- Undefined: no last_i port; frames are always exactly frame_len_p beats.

Decomposition:
- Package xor_accum_pkg holds the state enum (ACCUM, DONE) and a count-width helper function.
- Natural sub-module: xor_accum_beat_ctr, a clear/increment up-counter with terminal-count flag, parametrised by frame_len_p. It is reused for count_o.

Test Plan:
- Reset and idle: assert reset_n_i=0 mid-cycle (async) -> ready_o=1, valid_o=0, data_o=0, count_o=0 immediately without a clock edge.
- Basic frame (width_p=8, frame_len_p=4): send 0x01,0x02,0x04,0x08 back-to-back, ready_i=1 -> next cycle valid_o=1, data_o=0x0F, count_o=4, held one cycle. Then a new frame starts.
- Backpressure: frame 0xFF,0x0F,0xF0,0xAA with ready_i=0 for 5 cycles -> data_o=0xAA held stable with valid_o=1 and ready_o=0 throughout. Consumed on the first ready_i=1.
- Bubbles and self-cancel: 0x5A, bubble, 0x5A, bubble, 0x33, 0xCC -> data_o=0xFF. count_o steps 1,1,2,2,3.
- Reset mid-frame: accept 0x11,0x22, pulse reset_n_i low, then send 0x01,0x01,0x01,0x01 -> data_o=0x00, with no residue of the earlier words.
- XOR_ACCUM_LAST_EN: send 0x3C then 0x0F with last_i=1 -> data_o=0x33, count_o=2. The following full frame is unaffected.
